// File: rtl/data_cache_dm_pkg.sv
// data_cache_dm_pkg: FSM encoding and address-split width helpers shared by the cache.
package data_cache_dm_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_WT} state_e;
  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int calc_tag_w(input int addr_w, input int index_w, input int line_words);
    return addr_w - index_w - $clog2(line_words) - 2;
  endfunction
endpackage

// File: rtl/data_cache_dm_burst_ctr.sv
// cache_burst_ctr: word counter for memory bursts; wraps to 0 after the last word of a line.
module cache_burst_ctr #(
  parameter int OFF_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [OFF_W-1:0] cnt_o,
  output logic             last_o
);
  logic [OFF_W-1:0] cnt_q, cnt_d;
  assign cnt_d  = adv_i ? cnt_q + OFF_W'(1) : cnt_q;
  assign cnt_o  = cnt_q;
  assign last_o = &cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/data_cache_dm.sv
// data_cache_dm: direct-mapped data cache with word-serial memory port,
// selectable write-through/no-allocate or write-back/write-allocate policy.
module data_cache_dm import data_cache_dm_pkg::*; #(
  parameter int ADDR_W     = 11,
  parameter int INDEX_W    = 4,
  parameter int LINE_WORDS = 2,
  parameter int WRITE_BACK = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  input  logic              WE,
  input  logic              RE,
  output logic [31:0]       RD,
  output logic              Stall,
  output logic              Readhit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rd_access_cnt,
  output logic [31:0]       rd_hit_cnt
);
  localparam int OFF_W = calc_off_w(LINE_WORDS);
  localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, LINE_WORDS);
  localparam int NL    = 1 << INDEX_W;
  localparam bit WBACK = WRITE_BACK != 0;
  state_e state_q, state_d;
  logic [NL-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [NL];
  logic [31:0] data_q [NL][LINE_WORDS];
  logic [31:0] acc_q, hit_q;
  logic miss_q;
  logic [OFF_W-1:0] off, cnt;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic wr, rd, hit, last, adv, fill_done, wb_need;
  assign off = A[OFF_W+1:2];
  assign idx = A[OFF_W+2 +: INDEX_W];
  assign tag = A[ADDR_W-1 -: TAG_W];
  assign wr = WE;
  assign rd = RE & ~WE;
  assign hit = valid_q[idx] & (tag_q[idx] == tag);
  assign wb_need = WBACK & valid_q[idx] & dirty_q[idx];
  assign adv = mem_ready & (state_q == S_WB || state_q == S_REFILL);
  assign fill_done = state_q == S_REFILL && mem_ready && last;
  assign RD = data_q[idx][off];
  assign rd_access_cnt = acc_q;
  assign rd_hit_cnt = hit_q;
  cache_burst_ctr #(.OFF_W(OFF_W)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (adv),
    .cnt_o (cnt),
    .last_o(last)
  );
  always_comb begin
    state_d   = state_q;
    Stall     = 1'b1;
    Readhit   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        Stall   = (wr | rd) & (~hit | (wr & ~WBACK));
        Readhit = rd & hit;
        state_d = (wr & ~WBACK) ? S_WT :
                  ((wr | rd) & ~hit) ? (wb_need ? S_WB : S_REFILL) : S_IDLE;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx], idx, cnt, 2'b00};
        mem_wdata = data_q[idx][cnt];
        state_d   = (mem_ready & last) ? S_REFILL : S_WB;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, cnt, 2'b00};
        state_d  = (mem_ready & last) ? S_IDLE : S_REFILL;
      end
      S_WT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = A;
        mem_wdata = WD;
        Stall     = ~mem_ready;
        state_d   = mem_ready ? S_IDLE : S_WT;
      end
    endcase
    Stall   = Stall & rst_n;
    Readhit = Readhit & rst_n;
  end
  // miss_q remembers that the read now completing was a miss, so its final hit is not a first-cycle hit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      acc_q   <= '0;
      hit_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (state_q == S_IDLE && wr && hit && WBACK) dirty_q[idx] <= 1'b1;
      if (Readhit) acc_q <= acc_q + 32'd1;
      if (Readhit && !miss_q) hit_q <= hit_q + 32'd1;
      if (state_q == S_IDLE) miss_q <= rd & ~hit;
    end
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && mem_ready) data_q[idx][cnt] <= mem_rdata;
    if (fill_done) tag_q[idx] <= tag;
    if ((state_q == S_IDLE && wr && hit && WBACK) || (state_q == S_WT && mem_ready && hit))
      data_q[idx][off] <= WD;
  end
endmodule

// File: tb/tb_data_cache_dm.sv
// tb_data_cache_dm: drives a write-through (index 0) and a write-back (index 1) cache against
// an architectural-memory model plus a residency model of which line each index holds.
module tb_data_cache_dm;
  typedef struct packed {logic we; logic [10:0] addr; logic [31:0] data;} tx_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] a [2];
  logic [31:0] wd [2];
  logic we [2], re [2];
  logic [31:0] rd [2], mwdata [2], mrdata [2], acc [2], hcnt [2];
  logic stall [2], readhit [2], mreq [2], mwe [2], mready [2];
  logic [10:0] maddr [2];
  logic [31:0] mem [2][512], arch [2][512];
  int dly [2], wcnt [2];
  bit mv [2][16], md [2][16];
  logic [3:0] mt [2][16];
  logic [31:0] macc [2], mhit [2];
  tx_t txq [$], exq [$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign mready[g] = mreq[g] && (wcnt[g] == dly[g]);
    assign mrdata[g] = mem[g][maddr[g][10:2]];
    data_cache_dm #(.WRITE_BACK(g)) dut (
      .clk(clk), .rst_n(rst_n), .A(a[g]), .WD(wd[g]), .WE(we[g]), .RE(re[g]),
      .RD(rd[g]), .Stall(stall[g]), .Readhit(readhit[g]),
      .mem_req(mreq[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]), .mem_wdata(mwdata[g]),
      .mem_ready(mready[g]), .mem_rdata(mrdata[g]),
      .rd_access_cnt(acc[g]), .rd_hit_cnt(hcnt[g])
    );
  end

  task automatic tick(input int k, output logic s, output logic h, output logic [31:0] r);
    logic rq, rdy;
    @(negedge clk);
    s = stall[k]; h = readhit[k]; r = rd[k]; rq = mreq[k]; rdy = mready[k];
    if (rq && rdy) begin
      txq.push_back(tx_t'({mwe[k], maddr[k], mwe[k] ? mwdata[k] : mrdata[k]}));
      if (mwe[k]) mem[k][maddr[k][10:2]] = mwdata[k];
    end
    @(posedge clk);
    #1;
    wcnt[k] = (rq && !rdy) ? wcnt[k] + 1 : 0;
  endtask

  task automatic drive(input int k, input logic w, input logic r, input logic [10:0] ad,
                       input logic [31:0] d, output int st, output logic h,
                       output logic [31:0] rv, output bit ok);
    logic s;
    a[k] = ad; wd[k] = d; we[k] = w; re[k] = r;
    st = 0; ok = 0; h = 0; rv = '0;
    for (int c = 0; c < 300 && !ok; c++) begin
      tick(k, s, h, rv);
      if (s) st++;
      else ok = 1;
    end
    we[k] = 0; re[k] = 0;
  endtask

  // cache is transparent: reads return the architectural value; cost depends on residency
  task automatic model(input int k, input logic w, input logic [10:0] ad, input logic [31:0] d,
                       output int est, output logic eh, output logic [31:0] er);
    int n;
    logic [3:0] idx, tg;
    logic [8:0] wa, ba, va;
    bit hit;
    n = dly[k] + 1; idx = ad[6:3]; tg = ad[10:7]; wa = ad[10:2]; ba = {ad[10:3], 1'b0};
    hit = mv[k][idx] && mt[k][idx] == tg;
    est = 0; eh = 0; er = '0;
    if (w && k == 0) begin
      est = n;
      exq.push_back(tx_t'({1'b1, ad, d}));
      arch[k][wa] = d;
    end else begin
      if (!hit) begin
        est = 1 + 2 * n;
        if (k == 1 && mv[k][idx] && md[k][idx]) begin
          est += 2 * n;
          va = {mt[k][idx], idx, 1'b0};
          for (int i = 0; i < 2; i++)
            exq.push_back(tx_t'({1'b1, va + 9'(i), 2'b00, arch[k][va + 9'(i)]}));
        end
        for (int i = 0; i < 2; i++)
          exq.push_back(tx_t'({1'b0, ba + 9'(i), 2'b00, arch[k][ba + 9'(i)]}));
        mv[k][idx] = 1; mt[k][idx] = tg; md[k][idx] = 0;
      end
      if (w) begin
        md[k][idx] = 1;
        arch[k][wa] = d;
      end else begin
        eh = 1; er = arch[k][wa]; macc[k]++;
        if (hit) mhit[k]++;
      end
    end
  endtask

  task automatic run_op(input int k, input logic w, input logic r, input logic [10:0] ad,
                        input logic [31:0] d, output int st, output logic h, output logic [31:0] rv,
                        output int est, output logic eh, output logic [31:0] er, output bit ok);
    txq.delete(); exq.delete();
    model(k, w, ad, d, est, eh, er);
    drive(k, w, r, ad, d, st, h, rv, ok);
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      macc[k] = 0; mhit[k] = 0; wcnt[k] = 0;
      for (int i = 0; i < 16; i++) begin mv[k][i] = 0; md[k][i] = 0; mt[k][i] = 0; end
      for (int i = 0; i < 512; i++) arch[k][i] = mem[k][i];
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({stall[k], readhit[k], mreq[k], mwe[k]} !== 4'b0) begin
        bad++; $display("FAIL reset_ctl k=%0d: got %b want 0000", k, {stall[k], readhit[k], mreq[k], mwe[k]});
      end
      total++;
      if (acc[k] !== 32'd0 || hcnt[k] !== 32'd0) begin
        bad++; $display("FAIL reset_cnt k=%0d: got %0d/%0d want 0/0", k, acc[k], hcnt[k]);
      end
    end
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_read;
    int st, est; logic h, eh; logic [31:0] rv, er; bit ok;
    for (int k = 0; k < 2; k++) begin
      dly[k] = 0;
      run_op(k, 0, 1, 11'h010, 0, st, h, rv, est, eh, er, ok);
      total++;
      if (!ok || st !== 3 || st !== est) begin bad++; $display("FAIL cold_stall k=%0d: got %0d want 3", k, st); end
      total++;
      if (rv !== 32'h11111111 || h !== 1'b1) begin bad++; $display("FAIL cold_rd k=%0d: got %h/%b want 11111111/1", k, rv, h); end
      total++;
      if (acc[k] !== 32'd1 || hcnt[k] !== 32'd0) begin bad++; $display("FAIL cold_cnt k=%0d: got %0d/%0d want 1/0", k, acc[k], hcnt[k]); end
      total++;
      if (txq.size() != 2 || txq[0] !== exq[0] || txq[1] !== exq[1]) begin
        bad++; $display("FAIL cold_mem k=%0d: got %0d txns want 2", k, txq.size());
      end
      run_op(k, 0, 1, 11'h014, 0, st, h, rv, est, eh, er, ok);
      total++;
      if (!ok || st !== 0 || rv !== 32'h22222222 || h !== 1'b1) begin
        bad++; $display("FAIL hit_rd k=%0d: got stall=%0d rd=%h want 0/22222222", k, st, rv);
      end
      total++;
      if (hcnt[k] !== 32'd1 || acc[k] !== 32'd2 || txq.size() != 0) begin
        bad++; $display("FAIL hit_cnt k=%0d: got %0d/%0d want 2/1", k, acc[k], hcnt[k]);
      end
    end
  endtask

  task automatic test_write_through;
    int st, est; logic h, eh; logic [31:0] rv, er; bit ok;
    dly[0] = 3;
    run_op(0, 1, 0, 11'h010, 32'hDEADBEEF, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || st !== 4 || st !== est) begin bad++; $display("FAIL wt_stall: got %0d want 4", st); end
    total++;
    if (txq.size() != 1 || txq[0] !== tx_t'({1'b1, 11'h010, 32'hDEADBEEF})) begin
      bad++; $display("FAIL wt_mem: got %0d txns want 1", txq.size());
    end
    dly[0] = 0;
    run_op(0, 0, 1, 11'h010, 0, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || st !== 0 || rv !== 32'hDEADBEEF) begin bad++; $display("FAIL wt_readback: got %0d/%h want 0/deadbeef", st, rv); end
  endtask

  task automatic test_write_back;
    int st, est; logic h, eh; logic [31:0] rv, er; bit ok;
    dly[1] = 0;
    run_op(1, 1, 0, 11'h010, 32'hCAFEF00D, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || st !== 0 || txq.size() != 0) begin bad++; $display("FAIL wb_hit: got stall=%0d txns=%0d want 0/0", st, txq.size()); end
    run_op(1, 0, 1, 11'h090, 0, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || st !== 5 || st !== est) begin bad++; $display("FAIL wb_stall: got %0d want 5", st); end
    total++;
    if (txq.size() != 4) begin bad++; $display("FAIL wb_count: got %0d want 4", txq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (txq[i] !== exq[i]) begin bad++; $display("FAIL wb_tx%0d: got %h want %h", i, txq[i], exq[i]); end
      end
      total++;
      if (txq[0] !== tx_t'({1'b1, 11'h010, 32'hCAFEF00D}) || txq[1] !== tx_t'({1'b1, 11'h014, 32'h22222222})) begin
        bad++; $display("FAIL wb_victim: got %h %h", txq[0], txq[1]);
      end
    end
    total++;
    if (rv !== er) begin bad++; $display("FAIL wb_rd: got %h want %h", rv, er); end
  endtask

  task automatic test_rw_both;
    int st, est; logic h, eh; logic [31:0] rv, er; bit ok;
    run_op(1, 1, 1, 11'h090, 32'h5A5A1234, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || st !== 0 || h !== 1'b0 || acc[1] !== macc[1]) begin
      bad++; $display("FAIL rw_both: got stall=%0d rh=%b acc=%0d want 0/0/%0d", st, h, acc[1], macc[1]);
    end
    run_op(1, 0, 1, 11'h090, 0, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || rv !== 32'h5A5A1234) begin bad++; $display("FAIL rw_readback: got %h want 5a5a1234", rv); end
  endtask

  task automatic test_random;
    int st, est, op; logic h, eh, w, r; logic [31:0] rv, er, d; bit ok; logic [10:0] ad;
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 80; n++) begin
        op = $urandom_range(0, 99);
        w = op >= 50; r = op < 50 || op >= 85;
        ad = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 1'($urandom), 2'b00};
        dly[k] = $urandom_range(0, 2);
        d = $urandom;
        run_op(k, w, r, ad, d, st, h, rv, est, eh, er, ok);
        total++;
        if (!ok || st !== est) begin bad++; $display("FAIL rand_stall k=%0d a=%h: got %0d want %0d", k, ad, st, est); end
        total++;
        if (h !== eh) begin bad++; $display("FAIL rand_readhit k=%0d a=%h: got %b want %b", k, ad, h, eh); end
        if (eh) begin
          total++;
          if (rv !== er) begin bad++; $display("FAIL rand_rd k=%0d a=%h: got %h want %h", k, ad, rv, er); end
        end
        total++;
        if (txq.size() != exq.size()) begin
          bad++; $display("FAIL rand_txcount k=%0d a=%h: got %0d want %0d", k, ad, txq.size(), exq.size());
        end else
          for (int i = 0; i < txq.size(); i++) begin
            total++;
            if (txq[i] !== exq[i]) begin bad++; $display("FAIL rand_tx k=%0d: got %h want %h", k, txq[i], exq[i]); end
          end
        total++;
        if (acc[k] !== macc[k] || hcnt[k] !== mhit[k]) begin
          bad++; $display("FAIL rand_cnt k=%0d: got %0d/%0d want %0d/%0d", k, acc[k], hcnt[k], macc[k], mhit[k]);
        end
      end
  endtask

  task automatic test_reset_midrefill;
    int st, est; logic s, h, eh; logic [31:0] rv, er; bit ok;
    dly[0] = 4; a[0] = 11'h7F0; we[0] = 0; re[0] = 1;
    repeat (4) tick(0, s, h, rv);
    total++;
    if (mreq[0] !== 1'b1) begin bad++; $display("FAIL midrefill_req: got %b want 1", mreq[0]); end
    rst_n = 0; re[0] = 0;
    #1;
    total++;
    if ({mreq[0], mwe[0], stall[0], readhit[0]} !== 4'b0) begin
      bad++; $display("FAIL reset_drop: got %b want 0000", {mreq[0], mwe[0], stall[0], readhit[0]});
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    total++;
    if ({acc[0], hcnt[0], acc[1], hcnt[1]} !== 128'd0) begin bad++; $display("FAIL reset_cnt2: got %0d/%0d want 0/0", acc[0], hcnt[0]); end
    run_op(0, 0, 1, 11'h7F0, 0, st, h, rv, est, eh, er, ok);
    total++;
    if (!ok || st !== 11 || st !== est) begin bad++; $display("FAIL rerefill_stall: got %0d want 11", st); end
    total++;
    if (rv !== er || txq.size() != 2 || acc[0] !== 32'd1 || hcnt[0] !== 32'd0) begin
      bad++; $display("FAIL rerefill_rd: got %h txns=%0d want %h txns=2", rv, txq.size(), er);
    end
  endtask

  initial begin
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      a[k] = '0; wd[k] = '0; we[k] = 0; re[k] = 0; dly[k] = 0;
      for (int i = 0; i < 512; i++) mem[k][i] = $urandom;
      mem[k][4] = 32'h11111111;
      mem[k][5] = 32'h22222222;
    end
    model_reset();
    test_reset();
    test_cold_read();
    test_write_through();
    test_write_back();
    test_rw_both();
    test_random();
    test_reset_midrefill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
